// File: rtl/servant_clock_seq.sv
// Lock-qualified reset sequencer with per-channel divided clock-enable pulses.
// Optional lock-loss counter enabled by defining SERVANT_CLOCK_SEQ_LOSS_CNT_EN.
module servant_clock_seq #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_locked,
  input  logic [CHANNELS-1:0]       i_ch_en,
  input  logic [CHANNELS*DIV_W-1:0] i_div,
  output logic [CHANNELS-1:0]       o_ce,
  output logic                      o_rst,
  output logic [7:0]                o_lock_loss
);

  localparam int unsigned HOLD_W = 16;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                           state;
  logic                             lock_meta;
  logic                             lock_s;
  logic [HOLD_W-1:0]                hold_cnt;
  logic [CHANNELS-1:0][DIV_W-1:0]   cnt;
  logic [CHANNELS-1:0][DIV_W-1:0]   div_r;
  logic [CHANNELS-1:0]              en_r;
  logic                             enter_run;
  logic                             stay_run;

  // i_locked is asynchronous; only lock_s may be used downstream
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= i_locked;
      lock_s    <= lock_meta;
    end
  end

  assign enter_run = (state == HOLD) && lock_s && (hold_cnt == HOLD_LAST);
  assign stay_run  = (state == RUN) && lock_s;

  // Lock qualification: require RST_HOLD consecutive locked cycles before RUN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_LAST) state <= RUN;
          end
        end
        RUN: begin
          if (!lock_s) state <= WAIT_LOCK;
        end
        default: begin
          state    <= WAIT_LOCK;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign o_rst = (state != RUN);

  // Divider settings are only sampled at period boundaries so no period is cut short
  always_ff @(posedge i_clk) begin
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (i_rst) begin
        cnt[ch]   <= '0;
        div_r[ch] <= '0;
        en_r[ch]  <= 1'b0;
        o_ce[ch]  <= 1'b0;
      end else if (enter_run) begin
        cnt[ch]   <= '0;
        div_r[ch] <= i_div[ch*DIV_W +: DIV_W];
        en_r[ch]  <= i_ch_en[ch];
        o_ce[ch]  <= 1'b0;
      end else if (!stay_run) begin
        cnt[ch]   <= '0;
        o_ce[ch]  <= 1'b0;
      end else if (cnt[ch] == div_r[ch]) begin
        cnt[ch]   <= '0;
        o_ce[ch]  <= en_r[ch];
        div_r[ch] <= i_div[ch*DIV_W +: DIV_W];
        en_r[ch]  <= i_ch_en[ch];
      end else begin
        cnt[ch]   <= cnt[ch] + DIV_W'(1);
        o_ce[ch]  <= 1'b0;
      end
    end
  end

`ifdef SERVANT_CLOCK_SEQ_LOSS_CNT_EN
  logic leave_run;
  assign leave_run = (state == RUN) && !lock_s;

  // Saturating count of lock drops while running
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lock_loss <= 8'd0;
    end else if (leave_run && (o_lock_loss != 8'hFF)) begin
      o_lock_loss <= o_lock_loss + 8'd1;
    end
  end
`else
  assign o_lock_loss = 8'd0;
`endif

endmodule

// File: tb/tb_servant_clock_seq.sv
// Self-checking bench for servant_clock_seq: lock sequencing, divider table, corner sequences.
module tb_servant_clock_seq;

  localparam int unsigned CH         = 2;
  localparam int unsigned DW         = 8;
  localparam int unsigned HOLD       = 16;
  localparam int          LOCK_EDGES = HOLD + 3;
`ifdef SERVANT_CLOCK_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_locked = 1'b0;
  logic [CH-1:0]      i_ch_en = '0;
  logic [CH*DW-1:0]   i_div = '0;
  logic [CH-1:0]      o_ce;
  logic               o_rst;
  logic [7:0]         o_lock_loss;

  int total = 0;
  int bad   = 0;

  servant_clock_seq #(.CHANNELS(CH), .DIV_W(DW), .RST_HOLD(HOLD)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_locked    (i_locked),
    .i_ch_en     (i_ch_en),
    .i_div       (i_div),
    .o_ce        (o_ce),
    .o_rst       (o_rst),
    .o_lock_loss (o_lock_loss)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    i_locked = 1'b0;
    tick();
    tick();
    i_rst    = 1'b0;
  endtask

  // Raise lock and count edges (first sampling edge = 1) until o_rst falls
  task automatic lock_up(output int n, output int ce_seen);
    i_locked = 1'b1;
    n        = 0;
    ce_seen  = 0;
    while (o_rst && n < 100) begin
      tick();
      n++;
      if (o_rst && o_ce != '0) ce_seen++;
    end
  endtask

  function automatic bit exp_pulse(input int k, input int d, input bit en);
    return en && (k >= 1) && ((k % (d + 1)) == 0);
  endfunction

  typedef struct {
    int d0;
    int d1;
    bit e0;
    bit e1;
    int ncyc;
    int pulses0;
    int pulses1;
  } vec_t;

  vec_t        vecs[4];
  logic [1:0]  sb_q[$];
  logic [1:0]  exp_ce;

  initial begin
    int n;
    int ce_seen;
    int p0;
    int p1;

    vecs[0] = '{d0: 3,   d1: 0, e0: 1'b1, e1: 1'b1, ncyc: 24,  pulses0: 6,  pulses1: 24};
    vecs[1] = '{d0: 255, d1: 5, e0: 1'b1, e1: 1'b1, ncyc: 520, pulses0: 2,  pulses1: 86};
    vecs[2] = '{d0: 2,   d1: 2, e0: 1'b1, e1: 1'b0, ncyc: 30,  pulses0: 10, pulses1: 0};
    vecs[3] = '{d0: 0,   d1: 7, e0: 1'b0, e1: 1'b1, ncyc: 30,  pulses0: 0,  pulses1: 3};

    // Reset values
    do_reset();
    check("rst_o_rst", int'(o_rst), 1);
    check("rst_o_ce", int'(o_ce), 0);
    check("rst_loss", int'(o_lock_loss), 0);
    tick();
    check("wait_o_rst", int'(o_rst), 1);

    // Divider table with formula-based scoreboard
    for (int v = 0; v < 4; v++) begin
      do_reset();
      i_div   = {8'(vecs[v].d1), 8'(vecs[v].d0)};
      i_ch_en = {vecs[v].e1, vecs[v].e0};
      lock_up(n, ce_seen);
      check("lock_edges", n, LOCK_EDGES);
      check("ce_during_rst", ce_seen, 0);
      check("ce_entry", int'(o_ce), 0);
      p0 = 0;
      p1 = 0;
      for (int k = 1; k <= vecs[v].ncyc; k++) begin
        sb_q.push_back({exp_pulse(k, vecs[v].d1, vecs[v].e1),
                        exp_pulse(k, vecs[v].d0, vecs[v].e0)});
        tick();
        exp_ce = sb_q.pop_front();
        check($sformatf("ce_v%0d_k%0d", v, k), int'(o_ce), int'(exp_ce));
        p0 += int'(o_ce[0]);
        p1 += int'(o_ce[1]);
      end
      check($sformatf("pulses0_v%0d", v), p0, vecs[v].pulses0);
      check($sformatf("pulses1_v%0d", v), p1, vecs[v].pulses1);
    end

    // Mid-period change: period finishes, disabled period silent, then 2-cycle rate
    do_reset();
    i_div   = {8'd0, 8'd7};
    i_ch_en = 2'b01;
    lock_up(n, ce_seen);
    check("lock_edges_chg", n, LOCK_EDGES);
    for (int k = 1; k <= 22; k++) begin
      if (k == 4) begin
        i_div   = {8'd0, 8'd1};
        i_ch_en = 2'b00;
      end
      if (k == 12) i_ch_en = 2'b01;
      sb_q.push_back({1'b0, (k == 8) || (k >= 14 && (k % 2) == 0)});
      tick();
      exp_ce = sb_q.pop_front();
      check($sformatf("chg_k%0d", k), int'(o_ce), int'(exp_ce));
    end

    // Lock drop during RUN
    do_reset();
    i_div   = '0;
    i_ch_en = 2'b01;
    lock_up(n, ce_seen);
    check("lock_edges_drop", n, LOCK_EDGES);
    tick();
    tick();
    check("drop_pre_ce", int'(o_ce), 1);
    i_locked = 1'b0;
    tick();
    check("drop_e1_rst", int'(o_rst), 0);
    check("drop_e1_ce", int'(o_ce), 1);
    tick();
    check("drop_e2_rst", int'(o_rst), 0);
    check("drop_e2_ce", int'(o_ce), 1);
    tick();
    check("drop_e3_rst", int'(o_rst), 1);
    check("drop_e3_ce", int'(o_ce), 0);
    check("drop_loss", int'(o_lock_loss), LOSS_EN ? 1 : 0);

    // Glitch during HOLD restarts the full hold
    i_locked = 1'b1;
    repeat (8) tick();
    check("glitch_hold_rst", int'(o_rst), 1);
    i_locked = 1'b0;
    repeat (4) tick();
    check("glitch_low_rst", int'(o_rst), 1);
    lock_up(n, ce_seen);
    check("glitch_relock_edges", n, LOCK_EDGES);

    // Accumulate 300 lock losses in total
    for (int i = 0; i < 299; i++) begin
      i_locked = 1'b0;
      repeat (3) tick();
      lock_up(n, ce_seen);
      check("loss_relock_edges", n, LOCK_EDGES);
    end
    check("loss_sat", int'(o_lock_loss), LOSS_EN ? 255 : 0);

    // Reset mid-RUN takes priority
    tick();
    tick();
    check("run_ce_pre_rst", int'(o_ce), 1);
    i_rst = 1'b1;
    tick();
    check("midrun_rst_o_rst", int'(o_rst), 1);
    check("midrun_rst_ce", int'(o_ce), 0);
    check("midrun_rst_loss", int'(o_lock_loss), 0);

    // Reset mid-HOLD, then a clean full relock
    i_rst = 1'b0;
    repeat (10) tick();
    check("midhold_pre_rst", int'(o_rst), 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    lock_up(n, ce_seen);
    check("midhold_relock_edges", n, LOCK_EDGES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
